// File: rtl/nv_clk_gate_pkg.sv
// Shared types for the clock-gate enable controller: FSM state encoding and output decode helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nv_clk_gate_pkg;

    localparam int CG_STATE_W = 2;

    // ON: clock running and stable. OFF: clock gated. WAKE: clock re-enabled, settling.
    typedef enum logic [CG_STATE_W-1:0] {
        CG_ON   = 2'd0,
        CG_OFF  = 2'd1,
        CG_WAKE = 2'd2
    } cg_state_e;

    // Gate-cell enable implied by a state: only OFF stops the clock.
    function automatic logic cg_en_of(input cg_state_e s);
        return (s != CG_OFF);
    endfunction

    // Ready implied by a state: sources may only issue work once fully ON.
    function automatic logic cg_rdy_of(input cg_state_e s);
        return (s == CG_ON);
    endfunction

endpackage

// File: rtl/nv_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count visible one cycle after inc/clr.
// Backpressure: none; inc at all-ones is silently dropped.
module nv_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Hold at all-ones instead of wrapping so the count never aliases back to small values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nv_clk_gate_en_ctrl.sv
// Drives the gate-cell enable from source activity: gates after idle hysteresis, wakes on demand.
// Latency: busy in OFF -> clk_en next cycle, clk_rdy WAKE_DLY cycles later; idle -> gated after thresh+1.
// Backpressure: sources hold src_busy until clk_rdy; dropping busy during WAKE is allowed.
module nv_clk_gate_en_ctrl
    import nv_clk_gate_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_DLY   = 2,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [NUM_SRC-1:0]    src_busy,
    input  logic                  cfg_gate_en,
    input  logic                  cfg_force_on,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh,
    input  logic                  cfg_cnt_clr,
    output logic                  clk_en,
    output logic                  clk_rdy,
    output logic [STAT_W-1:0]     gate_cnt
);

    // Wide enough to hold WAKE_DLY, the value wake_cnt reaches on the WAKE exit cycle.
    localparam int WK_W = $clog2(WAKE_DLY + 1);
    localparam logic [WK_W-1:0] WAKE_LAST = WK_W'(WAKE_DLY - 1);

    cg_state_e             state;
    cg_state_e             state_nxt;
    logic                  idle;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  idle_clr;
    logic                  idle_inc;
    logic                  gate_inc;
    logic [WK_W-1:0]       wake_cnt;
    logic [WK_W-1:0]       wake_nxt;

    // Gating is allowed only when no source is busy, gating is enabled and not forced on.
    assign idle = ~|src_busy & cfg_gate_en & ~cfg_force_on;

    // Next-state and counter control. The threshold is compared live, so lowering it
    // below the running idle count gates on the very next idle cycle.
    always_comb begin
        state_nxt = state;
        idle_clr  = 1'b0;
        idle_inc  = 1'b0;
        gate_inc  = 1'b0;
        wake_nxt  = wake_cnt;
        case (state)
            CG_ON: begin
                if (!idle) begin
                    idle_clr = 1'b1;
                end else if (idle_cnt < cfg_idle_thresh) begin
                    idle_inc = 1'b1;
                end else begin
                    state_nxt = CG_OFF;
                    idle_clr  = 1'b1;
                    gate_inc  = 1'b1;
                end
            end
            CG_OFF: begin
                // Idle count is meaningless outside ON; keep it parked at zero.
                idle_clr = 1'b1;
                if (!idle) begin
                    state_nxt = CG_WAKE;
                    wake_nxt  = '0;
                end
            end
            CG_WAKE: begin
                // Idle is ignored here: once woken, the clock always settles to ON.
                idle_clr = 1'b1;
                wake_nxt = wake_cnt + 1'b1;
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = CG_ON;
                end
            end
            default: begin
                // Unused encoding: recover to the safe, clock-running state.
                state_nxt = CG_ON;
                idle_clr  = 1'b1;
            end
        endcase
    end

    // State, wake timer and registered outputs; outputs decode next-state so they
    // change on the same edge as the state and come straight from flops (glitch-free).
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= CG_ON;
            wake_cnt <= '0;
            clk_en   <= 1'b1;
            clk_rdy  <= 1'b1;
        end else begin
            state    <= state_nxt;
            wake_cnt <= wake_nxt;
            clk_en   <= cg_en_of(state_nxt);
            clk_rdy  <= cg_rdy_of(state_nxt);
        end
    end

    // Consecutive-idle hysteresis counter; never wraps.
    nv_sat_cnt #(
        .W (IDLE_CNT_W)
    ) u_idle_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .clr    (idle_clr),
        .inc    (idle_inc),
        .cnt    (idle_cnt)
    );

    // ON->OFF event statistics; software clear beats a same-cycle gating event.
    nv_sat_cnt #(
        .W (STAT_W)
    ) u_gate_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .clr    (cfg_cnt_clr),
        .inc    (gate_inc),
        .cnt    (gate_cnt)
    );

endmodule

// File: tb/tb_nv_clk_gate_en_ctrl.sv
module tb_nv_clk_gate_en_ctrl;

    localparam int NUM_SRC    = 4;
    localparam int IDLE_CNT_W = 8;
    localparam int WAKE_DLY   = 2;
    // Narrow statistics counter so its saturation point is reachable in a short run.
    localparam int STAT_W     = 6;
    localparam logic [STAT_W-1:0] SAT_MAX = '1;

    logic                  clk;
    logic                  reset_;
    logic [NUM_SRC-1:0]    src_busy;
    logic                  cfg_gate_en;
    logic                  cfg_force_on;
    logic [IDLE_CNT_W-1:0] cfg_idle_thresh;
    logic                  cfg_cnt_clr;
    logic                  clk_en;
    logic                  clk_rdy;
    logic [STAT_W-1:0]     gate_cnt;

    int n_chk = 0;
    int n_bad = 0;

    nv_clk_gate_en_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .IDLE_CNT_W (IDLE_CNT_W),
        .WAKE_DLY   (WAKE_DLY),
        .STAT_W     (STAT_W)
    ) dut (
        .clk             (clk),
        .reset_          (reset_),
        .src_busy        (src_busy),
        .cfg_gate_en     (cfg_gate_en),
        .cfg_force_on    (cfg_force_on),
        .cfg_idle_thresh (cfg_idle_thresh),
        .cfg_cnt_clr     (cfg_cnt_clr),
        .clk_en          (clk_en),
        .clk_rdy         (clk_rdy),
        .gate_cnt        (gate_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive busy, let one rising edge sample it, then check outputs on the falling edge.
    task automatic cyc(input logic [NUM_SRC-1:0] b, input logic e_en, input logic e_rdy, input string tag);
        src_busy = b;
        @(negedge clk);
        chk({tag, ".en"}, 32'(clk_en), 32'(e_en));
        chk({tag, ".rdy"}, 32'(clk_rdy), 32'(e_rdy));
    endtask

    initial begin
        reset_          = 1'b0;
        src_busy        = '0;
        cfg_gate_en     = 1'b1;
        cfg_force_on    = 1'b0;
        cfg_idle_thresh = 8'd3;
        cfg_cnt_clr     = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst.en", 32'(clk_en), 32'd1);
        chk("rst.rdy", 32'(clk_rdy), 32'd1);
        chk("rst.cnt", 32'(gate_cnt), 32'd0);

        // 1: idle from release, thresh=3 -> on for 4 cycles then gated
        reset_ = 1'b1;
        cyc('0, 1'b1, 1'b1, "t1.c1");
        cyc('0, 1'b1, 1'b1, "t1.c2");
        cyc('0, 1'b1, 1'b1, "t1.c3");
        cyc('0, 1'b0, 1'b0, "t1.c4");
        chk("t1.cnt", 32'(gate_cnt), 32'd1);

        // 2: one-cycle pulse on src_busy[2] wakes; rdy two cycles after en; re-gate after 4 idle
        cyc(4'b0100, 1'b1, 1'b0, "t2.wk1");
        cyc('0, 1'b1, 1'b0, "t2.wk2");
        cyc('0, 1'b1, 1'b1, "t2.on");
        cyc('0, 1'b1, 1'b1, "t2.i1");
        cyc('0, 1'b1, 1'b1, "t2.i2");
        cyc('0, 1'b1, 1'b1, "t2.i3");
        cyc('0, 1'b0, 1'b0, "t2.off");
        chk("t2.cnt", 32'(gate_cnt), 32'd2);

        // 3: thresh=0 with toggling busy; idle in WAKE ignored, rdy only once ON
        cfg_idle_thresh = 8'd0;
        for (int i = 0; i < 2; i++) begin
            cyc(4'b0001, 1'b1, 1'b0, "t3.wk1");
            cyc('0, 1'b1, 1'b0, "t3.wk2");
            cyc(4'b1000, 1'b1, 1'b1, "t3.on");
            cyc('0, 1'b0, 1'b0, "t3.off");
        end
        chk("t3.cnt", 32'(gate_cnt), 32'd4);

        // 4a: gate_en=0 while OFF -> wake and hold on, count frozen
        cfg_gate_en = 1'b0;
        cyc('0, 1'b1, 1'b0, "t4a.wk1");
        cyc('0, 1'b1, 1'b0, "t4a.wk2");
        cyc('0, 1'b1, 1'b1, "t4a.on");
        for (int i = 0; i < 20; i++) cyc('0, 1'b1, 1'b1, "t4a.hold");
        chk("t4a.cnt", 32'(gate_cnt), 32'd4);
        cfg_gate_en = 1'b1;
        cyc('0, 1'b0, 1'b0, "t4a.regate");
        chk("t4a.cnt2", 32'(gate_cnt), 32'd5);

        // 4b: force_on=1 while OFF -> same behaviour
        cfg_force_on = 1'b1;
        cyc('0, 1'b1, 1'b0, "t4b.wk1");
        cyc('0, 1'b1, 1'b0, "t4b.wk2");
        cyc('0, 1'b1, 1'b1, "t4b.on");
        for (int i = 0; i < 20; i++) cyc('0, 1'b1, 1'b1, "t4b.hold");
        chk("t4b.cnt", 32'(gate_cnt), 32'd5);
        cfg_force_on = 1'b0;
        cyc('0, 1'b0, 1'b0, "t4b.regate");
        chk("t4b.cnt2", 32'(gate_cnt), 32'd6);

        // 5: 60 more gating events from 6 -> saturates at all-ones, then holds
        for (int i = 0; i < 60; i++) begin
            cyc(4'b0010, 1'b1, 1'b0, "t5.wk1");
            cyc('0, 1'b1, 1'b0, "t5.wk2");
            cyc(4'b0010, 1'b1, 1'b1, "t5.on");
            cyc('0, 1'b0, 1'b0, "t5.off");
        end
        chk("t5.sat", 32'(gate_cnt), 32'(SAT_MAX));
        cyc(4'b0010, 1'b1, 1'b0, "t5h.wk1");
        cyc('0, 1'b1, 1'b0, "t5h.wk2");
        cyc(4'b0010, 1'b1, 1'b1, "t5h.on");
        cyc('0, 1'b0, 1'b0, "t5h.off");
        chk("t5.hold", 32'(gate_cnt), 32'(SAT_MAX));

        // 5b: clear coincident with a gating event -> 0
        cyc(4'b0010, 1'b1, 1'b0, "t5c.wk1");
        cyc('0, 1'b1, 1'b0, "t5c.wk2");
        cyc(4'b0010, 1'b1, 1'b1, "t5c.on");
        cfg_cnt_clr = 1'b1;
        cyc('0, 1'b0, 1'b0, "t5c.off");
        cfg_cnt_clr = 1'b0;
        chk("t5c.cnt", 32'(gate_cnt), 32'd0);

        // Live threshold: count to 3 under thresh=7, lower to 1 -> gates on next idle cycle
        cfg_idle_thresh = 8'd7;
        cyc(4'b0001, 1'b1, 1'b0, "lt.wk1");
        cyc('0, 1'b1, 1'b0, "lt.wk2");
        cyc('0, 1'b1, 1'b1, "lt.on");
        cyc('0, 1'b1, 1'b1, "lt.i1");
        cyc('0, 1'b1, 1'b1, "lt.i2");
        cyc('0, 1'b1, 1'b1, "lt.i3");
        cfg_idle_thresh = 8'd1;
        cyc('0, 1'b0, 1'b0, "lt.off");
        chk("lt.cnt", 32'(gate_cnt), 32'd1);

        // 6a: async reset while OFF, checked before any rising edge
        reset_ = 1'b0;
        #1;
        chk("t6a.en", 32'(clk_en), 32'd1);
        chk("t6a.rdy", 32'(clk_rdy), 32'd1);
        chk("t6a.cnt", 32'(gate_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t6a.hold", 32'(clk_en), 32'd1);
        reset_ = 1'b1;
        cyc('0, 1'b1, 1'b1, "t6.i1");
        cyc('0, 1'b0, 1'b0, "t6.off");
        chk("t6.cnt", 32'(gate_cnt), 32'd1);

        // 6b: async reset mid-WAKE
        cyc(4'b0100, 1'b1, 1'b0, "t6b.wk1");
        src_busy = 4'b0100;
        reset_   = 1'b0;
        #1;
        chk("t6b.en", 32'(clk_en), 32'd1);
        chk("t6b.rdy", 32'(clk_rdy), 32'd1);
        chk("t6b.cnt", 32'(gate_cnt), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        cyc(4'b0100, 1'b1, 1'b1, "t6b.on");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
